// File: rtl/tmds_pkg.sv
// Shared constants and helpers for the multi-lane TMDS encoder.
// Contents: period-type codes, fixed control/guard-band symbols,
// TERC4 lookup and an 8-bit popcount.
package tmds_pkg;

  localparam logic [2:0] MODE_CTRL  = 3'd0;
  localparam logic [2:0] MODE_VIDEO = 3'd1;
  localparam logic [2:0] MODE_VGB   = 3'd2;
  localparam logic [2:0] MODE_DIGB  = 3'd3;
  localparam logic [2:0] MODE_TERC4 = 3'd4;

  localparam logic [9:0] CTRL_00 = 10'b1101010100;
  localparam logic [9:0] CTRL_01 = 10'b0010101011;
  localparam logic [9:0] CTRL_10 = 10'b0101010100;
  localparam logic [9:0] CTRL_11 = 10'b1010101011;

  // Guard-band symbols: GB_A on video roles 0/2, GB_B on role 1 and data-island roles 1/2
  localparam logic [9:0] GB_A = 10'b1011001100;
  localparam logic [9:0] GB_B = 10'b0100110011;

  function automatic logic [9:0] ctrl_code(input logic [1:0] c);
    logic [9:0] res;
    case (c)
      2'b00:   res = CTRL_00;
      2'b01:   res = CTRL_01;
      2'b10:   res = CTRL_10;
      default: res = CTRL_11;
    endcase
    return res;
  endfunction

  function automatic logic [9:0] terc4_lut(input logic [3:0] n);
    logic [9:0] res;
    case (n)
      4'h0:    res = 10'b1010011100;
      4'h1:    res = 10'b1001100011;
      4'h2:    res = 10'b1011100100;
      4'h3:    res = 10'b1011100010;
      4'h4:    res = 10'b0101110001;
      4'h5:    res = 10'b0100011110;
      4'h6:    res = 10'b0110001110;
      4'h7:    res = 10'b0100111100;
      4'h8:    res = 10'b1011001100;
      4'h9:    res = 10'b0100111001;
      4'hA:    res = 10'b0110011100;
      4'hB:    res = 10'b1011000110;
      4'hC:    res = 10'b1010001110;
      4'hD:    res = 10'b1001110001;
      4'hE:    res = 10'b0101100011;
      default: res = 10'b1011000011;
    endcase
    return res;
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] d);
    logic [3:0] s;
    s = '0;
    for (int i = 0; i < 8; i++) s = s + 4'(d[i]);
    return s;
  endfunction

endpackage

// File: rtl/tmds_lane.sv
// One TMDS lane: stage 1 forms the transition-minimised q_m word and
// registers the period type; stage 2 applies DC balance and selects the
// final symbol, tracking this lane's running disparity.
// Ports: clk, rst_n, en (advance), mode, data[7:0], ctrl[1:0], terc4[3:0]
//        -> q_out[9:0] (registered symbol), disp (registered disparity).
module tmds_lane
  import tmds_pkg::*;
#(
  parameter int unsigned ROLE  = 0,
  parameter int unsigned CNT_W = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [2:0]              mode,
  input  logic [7:0]              data,
  input  logic [1:0]              ctrl,
  input  logic [3:0]              terc4,
  output logic [9:0]              q_out,
  output logic signed [CNT_W-1:0] disp
);

  localparam logic signed [CNT_W-1:0] C_ZERO  = '0;
  localparam logic signed [CNT_W-1:0] C_TWO   = CNT_W'(2);
  localparam logic signed [CNT_W-1:0] C_EIGHT = CNT_W'(8);

  logic [2:0]              r_mode;
  logic [8:0]              r_qm;
  logic [1:0]              r_ctrl;
  logic [3:0]              r_terc4;
  logic [9:0]              r_q;
  logic signed [CNT_W-1:0] r_cnt;

  logic [3:0]              w_n1_d;
  logic                    w_xnor;
  logic                    w_acc;
  logic [8:0]              w_qm;
  logic [3:0]              w_n1_q;
  logic signed [CNT_W-1:0] w_diff;
  logic signed [CNT_W-1:0] w_cnt_nxt;
  logic [9:0]              w_q_nxt;

  // Stage-1 transition minimisation; XNOR is an XOR chain with an extra inversion
  always_comb begin
    w_n1_d = popcount8(data);
    w_xnor = (w_n1_d > 4'd4) || ((w_n1_d == 4'd4) && !data[0]);
    w_qm   = '0;
    w_acc  = data[0];
    w_qm[0] = w_acc;
    for (int k = 1; k < 8; k++) begin
      w_acc   = w_acc ^ data[k] ^ w_xnor;
      w_qm[k] = w_acc;
    end
    w_qm[8] = ~w_xnor;
  end

  // Stage-1 registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode  <= MODE_CTRL;
      r_qm    <= '0;
      r_ctrl  <= '0;
      r_terc4 <= '0;
    end else if (en) begin
      r_mode  <= mode;
      r_qm    <= w_qm;
      r_ctrl  <= ctrl;
      r_terc4 <= terc4;
    end
  end

  // Stage-2 DC balance and symbol select; w_diff is N1-N0 of q_m[7:0]
  always_comb begin
    w_n1_q    = popcount8(r_qm[7:0]);
    w_diff    = $signed(CNT_W'({w_n1_q, 1'b0})) - C_EIGHT;
    w_q_nxt   = CTRL_00;
    w_cnt_nxt = C_ZERO;
    case (r_mode)
      MODE_VIDEO: begin
        if ((r_cnt == C_ZERO) || (w_n1_q == 4'd4)) begin
          w_q_nxt   = {~r_qm[8], r_qm[8], r_qm[8] ? r_qm[7:0] : ~r_qm[7:0]};
          w_cnt_nxt = r_qm[8] ? (r_cnt + w_diff) : (r_cnt - w_diff);
        end else if (r_cnt[CNT_W-1] == w_diff[CNT_W-1]) begin
          // both are non-zero here, so equal sign bits mean same polarity
          w_q_nxt   = {1'b1, r_qm[8], ~r_qm[7:0]};
          w_cnt_nxt = r_cnt + (r_qm[8] ? C_TWO : C_ZERO) - w_diff;
        end else begin
          w_q_nxt   = {1'b0, r_qm[8], r_qm[7:0]};
          w_cnt_nxt = r_cnt - (r_qm[8] ? C_ZERO : C_TWO) + w_diff;
        end
      end
      MODE_VGB:   w_q_nxt = (ROLE == 32'd1) ? GB_B : GB_A;
      MODE_DIGB:  w_q_nxt = (ROLE == 32'd0) ? terc4_lut(r_terc4) : GB_B;
      MODE_TERC4: w_q_nxt = terc4_lut(r_terc4);
      default:    w_q_nxt = ctrl_code(r_ctrl);
    endcase
  end

  // Stage-2 registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= CTRL_00;
      r_cnt <= C_ZERO;
    end else if (en) begin
      r_q   <= w_q_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  assign q_out = r_q;
  assign disp  = r_cnt;

endmodule

// File: rtl/tmds_multi_encoder.sv
// Multi-lane TMDS encoder: NUM_CH independent lanes sharing mode and en,
// lane i taking HDMI channel role (i mod 3). Two-cycle latency.
// Ports: clk, rst_n, en, mode[2:0], data[8*NUM_CH], ctrl[2*NUM_CH],
//        terc4[4*NUM_CH] -> q_out[10*NUM_CH], disp[CNT_W*NUM_CH].
module tmds_multi_encoder
  import tmds_pkg::*;
#(
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned CNT_W  = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [2:0]                mode,
  input  logic [8*NUM_CH-1:0]       data,
  input  logic [2*NUM_CH-1:0]       ctrl,
  input  logic [4*NUM_CH-1:0]       terc4,
  output logic [10*NUM_CH-1:0]      q_out,
  output logic [CNT_W*NUM_CH-1:0]   disp
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_lane
    tmds_lane #(
      .ROLE  (32'(g % 3)),
      .CNT_W (CNT_W)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .mode  (mode),
      .data  (data[8*g +: 8]),
      .ctrl  (ctrl[2*g +: 2]),
      .terc4 (terc4[4*g +: 4]),
      .q_out (q_out[10*g +: 10]),
      .disp  (disp[CNT_W*g +: CNT_W])
    );
  end

endmodule

// File: tb/tb_tmds_multi_encoder.sv
// Self-checking bench for tmds_multi_encoder with a behavioural reference
// model (integer disparity, raw-input stage holding, table-driven symbols).
module tb_tmds_multi_encoder;

  localparam int unsigned NUM_CH = 3;
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned DW     = 8 * NUM_CH;
  localparam int unsigned CW     = 2 * NUM_CH;
  localparam int unsigned TW     = 4 * NUM_CH;
  localparam int unsigned QW     = 10 * NUM_CH;
  localparam int unsigned PW     = CNT_W * NUM_CH;
  localparam logic [9:0]  SYM_C00 = 10'b1101010100;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [2:0]    mode;
  logic [DW-1:0] data;
  logic [CW-1:0] ctrl;
  logic [TW-1:0] terc4;
  logic [QW-1:0] q_out;
  logic [PW-1:0] disp;

  int checks = 0;
  int errors = 0;

  tmds_multi_encoder #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .mode  (mode),
    .data  (data),
    .ctrl  (ctrl),
    .terc4 (terc4),
    .q_out (q_out),
    .disp  (disp)
  );

  always #5 clk = ~clk;

  // reference model state: the held raw input sample, plus per-lane output/cnt
  logic [2:0] s1_mode;
  logic [7:0] s1_data  [NUM_CH];
  logic [1:0] s1_ctrl  [NUM_CH];
  logic [3:0] s1_terc4 [NUM_CH];
  logic [9:0] m_q      [NUM_CH];
  int         m_cnt    [NUM_CH];

  function automatic logic [9:0] ref_ctrl(input logic [1:0] c);
    logic [9:0] r;
    case (c)
      2'b00: r = 10'b1101010100;
      2'b01: r = 10'b0010101011;
      2'b10: r = 10'b0101010100;
      default: r = 10'b1010101011;
    endcase
    return r;
  endfunction

  function automatic logic [9:0] ref_terc4(input logic [3:0] n);
    logic [9:0] tab [16];
    tab = '{10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
            10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
            10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
            10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};
    return tab[n];
  endfunction

  function automatic logic [9:0] ref_enc(input int role, input logic [2:0] md,
                                         input logic [7:0] d, input logic [1:0] c,
                                         input logic [3:0] t, inout int cnt);
    logic [9:0] res;
    logic [7:0] qm;
    logic       qm8;
    bit         use_xnor;
    int         n1, n1q, n0q;
    if (md == 3'd1) begin
      n1 = $countones(d);
      use_xnor = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
      qm[0] = d[0];
      for (int k = 1; k < 8; k++)
        qm[k] = use_xnor ? ~(qm[k-1] ^ d[k]) : (qm[k-1] ^ d[k]);
      qm8 = !use_xnor;
      n1q = $countones(qm);
      n0q = 8 - n1q;
      if (cnt == 0 || n1q == n0q) begin
        res = {~qm8, qm8, qm8 ? qm : ~qm};
        cnt += qm8 ? (n1q - n0q) : (n0q - n1q);
      end else if ((cnt > 0 && n1q > n0q) || (cnt < 0 && n0q > n1q)) begin
        res = {1'b1, qm8, ~qm};
        cnt += (qm8 ? 2 : 0) + n0q - n1q;
      end else begin
        res = {1'b0, qm8, qm};
        cnt += (qm8 ? 0 : -2) + n1q - n0q;
      end
    end else begin
      cnt = 0;
      case (md)
        3'd2:    res = (role == 1) ? 10'b0100110011 : 10'b1011001100;
        3'd3:    res = (role == 0) ? ref_terc4(t) : 10'b0100110011;
        3'd4:    res = ref_terc4(t);
        default: res = ref_ctrl(c);
      endcase
    end
    return res;
  endfunction

  task automatic model_reset();
    s1_mode = 3'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      s1_data[i] = '0; s1_ctrl[i] = '0; s1_terc4[i] = '0;
      m_q[i] = SYM_C00; m_cnt[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < NUM_CH; i++)
      m_q[i] = ref_enc(i % 3, s1_mode, s1_data[i], s1_ctrl[i], s1_terc4[i], m_cnt[i]);
    s1_mode = mode;
    for (int i = 0; i < NUM_CH; i++) begin
      s1_data[i]  = data[8*i +: 8];
      s1_ctrl[i]  = ctrl[2*i +: 2];
      s1_terc4[i] = terc4[4*i +: 4];
    end
  endtask

  function automatic logic [QW-1:0] model_q();
    logic [QW-1:0] v;
    for (int i = 0; i < NUM_CH; i++) v[10*i +: 10] = m_q[i];
    return v;
  endfunction

  function automatic logic [PW-1:0] model_d();
    logic [PW-1:0] v;
    for (int i = 0; i < NUM_CH; i++) v[CNT_W*i +: CNT_W] = CNT_W'(m_cnt[i]);
    return v;
  endfunction

  // one clock: advance the model in step with the DUT, then settle past the edge
  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset();
    else if (en) model_step();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; mode = 3'd1; data = DW'($urandom);
    ctrl = '0; terc4 = '0;
    model_reset();
    repeat (3) cycle();
    for (int i = 0; i < NUM_CH; i++) begin
      checks++;
      if (q_out[10*i +: 10] !== SYM_C00 || disp[CNT_W*i +: CNT_W] !== '0) begin
        errors++;
        $display("FAIL reset_hold lane%0d q_out=%b disp=%0d want q_out=%b disp=0",
                 i, q_out[10*i +: 10], disp[CNT_W*i +: CNT_W], SYM_C00);
      end
    end
    mode = 3'd0; ctrl = '0; rst_n = 1'b1;
    for (int c = 0; c < 2; c++) begin
      cycle();
      for (int i = 0; i < NUM_CH; i++) begin
        checks++;
        if (q_out[10*i +: 10] !== SYM_C00 || disp[CNT_W*i +: CNT_W] !== '0) begin
          errors++;
          $display("FAIL reset_release c%0d lane%0d q_out=%b want %b",
                   c, i, q_out[10*i +: 10], SYM_C00);
        end
      end
    end
  endtask

  task automatic test_video_zero();
    logic [9:0] zq [3];
    int         zd [3];
    zq = '{10'h100, 10'h3FF, 10'h100};
    zd = '{-8, 2, -6};
    for (int k = 0; k < 5; k++) begin
      if (k < 3) begin mode = 3'd1; data = '0; end
      else begin mode = 3'd0; ctrl = '0; end
      cycle();
      if (k >= 1 && k <= 3) begin
        for (int i = 0; i < NUM_CH; i++) begin
          checks++;
          if (q_out[10*i +: 10] !== zq[k-1] || disp[CNT_W*i +: CNT_W] !== CNT_W'(zd[k-1])) begin
            errors++;
            $display("FAIL video_zero s%0d lane%0d q_out=%h disp=%0d want q_out=%h disp=%0d",
                     k-1, i, q_out[10*i +: 10], $signed(disp[CNT_W*i +: CNT_W]), zq[k-1], zd[k-1]);
          end
        end
      end
    end
  endtask

  task automatic test_ctrl();
    mode = 3'd0; ctrl = {2'b11, 2'b10, 2'b01};
    cycle();
    cycle();
    checks++;
    if (q_out !== {10'b1010101011, 10'b0101010100, 10'b0010101011} || disp !== '0) begin
      errors++;
      $display("FAIL ctrl_codes q_out=%b disp=%h", q_out, disp);
    end
  endtask

  task automatic test_guard();
    mode = 3'd1;
    for (int k = 0; k < 6; k++) begin
      data = DW'($urandom);
      cycle();
      checks++;
      if (q_out !== model_q() || disp !== model_d()) begin
        errors++;
        $display("FAIL guard_burst k%0d q_out=%h want %h disp=%h want %h",
                 k, q_out, model_q(), disp, model_d());
      end
    end
    mode = 3'd2; cycle();
    mode = 3'd3; terc4 = {4'($urandom), 4'($urandom), 4'hC}; cycle();
    checks++;
    if (q_out !== {10'b1011001100, 10'b0100110011, 10'b1011001100}) begin
      errors++;
      $display("FAIL vgb q_out=%b", q_out);
    end
    mode = 3'd4; terc4 = '0; cycle();
    checks++;
    if (q_out !== {10'b0100110011, 10'b0100110011, 10'b1010001110} || disp !== '0) begin
      errors++;
      $display("FAIL digb q_out=%b disp=%h want disp 0", q_out, disp);
    end
    mode = 3'd0; ctrl = '0; cycle();
    checks++;
    if (q_out !== {3{10'b1010011100}}) begin
      errors++;
      $display("FAIL terc4_zero q_out=%b", q_out);
    end
  endtask

  task automatic test_random_modes();
    for (int k = 0; k < 150; k++) begin
      mode = 3'($urandom_range(0, 7));
      data = DW'($urandom); ctrl = CW'($urandom); terc4 = TW'($urandom);
      cycle();
      checks++;
      if (q_out !== model_q() || disp !== model_d()) begin
        errors++;
        $display("FAIL rand_modes k%0d q_out=%h want %h disp=%h want %h",
                 k, q_out, model_q(), disp, model_d());
      end
    end
  endtask

  task automatic test_en_toggle();
    mode = 3'd1;
    for (int k = 0; k < 300; k++) begin
      data = DW'($urandom);
      en = ($urandom_range(0, 99) >= 30);
      cycle();
      checks++;
      if (q_out !== model_q() || disp !== model_d()) begin
        errors++;
        $display("FAIL en_toggle k%0d en=%0b q_out=%h want %h disp=%h want %h",
                 k, en, q_out, model_q(), disp, model_d());
      end
    end
    en = 1'b1;
  endtask

  task automatic test_async_reset();
    en = 1'b1; mode = 3'd1;
    for (int k = 0; k < 4; k++) begin
      data = DW'($urandom);
      cycle();
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (q_out !== {NUM_CH{SYM_C00}} || disp !== '0) begin
      errors++;
      $display("FAIL async_reset q_out=%b disp=%h", q_out, disp);
    end
    model_reset();
    cycle();
    rst_n = 1'b1; mode = 3'd1; data = '0;
    cycle();
    mode = 3'd0; ctrl = '0;
    cycle();
    for (int i = 0; i < NUM_CH; i++) begin
      checks++;
      if (q_out[10*i +: 10] !== 10'h100 || disp[CNT_W*i +: CNT_W] !== CNT_W'(-8)) begin
        errors++;
        $display("FAIL post_reset_video lane%0d q_out=%h disp=%0d want 100 / -8",
                 i, q_out[10*i +: 10], $signed(disp[CNT_W*i +: CNT_W]));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; mode = '0; data = '0; ctrl = '0; terc4 = '0;
    test_reset();
    test_video_zero();
    test_ctrl();
    test_guard();
    test_random_modes();
    test_en_toggle();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
